// File: rtl/divider_8by4.sv
// Signed 8-by-4 truncating divider: restoring magnitude divide over eight cycles,
// then a single sign-fix cycle, with a valid/ready handshake on each side.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one restoring iteration per cycle, eight in total
// FIX   | apply quotient/remainder signs, load result registers
// DONE  | result held until out_ready, out_valid=1
module divider_8by4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] Dividend,
    input  logic [3:0] Divisor,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] Quotient,
    output logic [3:0] Remainder,
    output logic       Div_By_Zero,
    output logic       Overflow
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t     r_state;
    state_t     w_next;

    logic [7:0] r_quo;
    logic [3:0] r_rem;
    logic [3:0] r_div;
    logic [2:0] r_cnt;
    logic       r_q_neg;
    logic       r_r_neg;

    logic       w_accept;
    logic       w_dbz;
    logic       w_ovf;
    logic [7:0] w_dvd_abs;
    logic [3:0] w_dvs_abs;
    logic [4:0] w_shift;
    logic       w_ge;
    logic [3:0] w_sub;
    logic [7:0] w_quo_fix;
    logic [3:0] w_rem_fix;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid & in_ready;
    assign w_dbz     = (Divisor == 4'h0);
    assign w_ovf     = (Dividend == 8'h80) && (Divisor == 4'hF);

    // Magnitudes are unsigned, so -128 and -8 map cleanly to 8'h80 and 4'h8.
    assign w_dvd_abs = Dividend[7] ? (~Dividend + 8'd1) : Dividend;
    assign w_dvs_abs = Divisor[3]  ? (~Divisor + 4'd1)  : Divisor;

    // Partial remainder stays below the divisor (<= 8), so 4 bits plus the shifted-in bit suffice.
    assign w_shift   = {r_rem, r_quo[7]};
    assign w_ge      = (w_shift >= {1'b0, r_div});
    assign w_sub     = w_shift[3:0] - r_div;

    assign w_quo_fix = r_q_neg ? (~r_quo + 8'd1) : r_quo;
    assign w_rem_fix = r_r_neg ? (~r_rem + 4'd1) : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (w_dbz || w_ovf) ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == 3'd0) begin
                    w_next = FIX;
                end
            end
            FIX:  w_next = DONE;
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo       <= 8'h00;
            r_rem       <= 4'h0;
            r_div       <= 4'h0;
            r_cnt       <= 3'd0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            Quotient    <= 8'h00;
            Remainder   <= 4'h0;
            Div_By_Zero <= 1'b0;
            Overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_dbz) begin
                            Quotient    <= 8'hFF;
                            Remainder   <= 4'h0;
                            Div_By_Zero <= 1'b1;
                            Overflow    <= 1'b0;
                        end else if (w_ovf) begin
                            Quotient    <= 8'h80;
                            Remainder   <= 4'h0;
                            Div_By_Zero <= 1'b0;
                            Overflow    <= 1'b1;
                        end else begin
                            r_quo   <= w_dvd_abs;
                            r_rem   <= 4'h0;
                            r_div   <= w_dvs_abs;
                            r_cnt   <= 3'd7;
                            r_q_neg <= Dividend[7] ^ Divisor[3];
                            r_r_neg <= Dividend[7];
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_ge ? w_sub : w_shift[3:0];
                    r_quo <= {r_quo[6:0], w_ge};
                    r_cnt <= r_cnt - 3'd1;
                end
                FIX: begin
                    Quotient    <= w_quo_fix;
                    Remainder   <= w_rem_fix;
                    Div_By_Zero <= 1'b0;
                    Overflow    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_8by4.sv
// Bench for divider_8by4: directed vector table, reset/hold sequences and an
// exhaustive operand sweep with random handshakes against an arithmetic model.
module tb_divider_8by4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] Dividend;
    logic [3:0] Divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Quotient;
    logic [3:0] Remainder;
    logic       Div_By_Zero;
    logic       Overflow;

    int n_cmp = 0;
    int n_err = 0;

    divider_8by4 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Dividend   (Dividend),
        .Divisor    (Divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Quotient   (Quotient),
        .Remainder  (Remainder),
        .Div_By_Zero(Div_By_Zero),
        .Overflow   (Overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        logic       o;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Truncating signed division from plain integer arithmetic.
    task automatic model(input logic [7:0] a, input logic [3:0] b,
                         output logic [7:0] q, output logic [3:0] r,
                         output logic z, output logic o, output int lat);
        int sa;
        int sb;
        int iq;
        int ir;
        sa = int'($signed(a));
        sb = int'($signed(b));
        z = 1'b0;
        o = 1'b0;
        if (sb == 0) begin
            q = 8'hFF; r = 4'h0; z = 1'b1; lat = 1;
        end else if (sa == -128 && sb == -1) begin
            q = 8'h80; r = 4'h0; o = 1'b1; lat = 1;
        end else begin
            iq = sa / sb;
            ir = sa % sb;
            q = iq[7:0];
            r = ir[3:0];
            lat = 10;
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er,
                          input logic ez, input logic eo, input int elat,
                          input int hold, input bit rnd, input string tag);
        int t;
        int lat;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (rnd) begin
            repeat ($urandom_range(0, 1)) begin
                in_valid = 1'b0;
                out_ready = 1'($urandom);
                @(posedge clk); #1;
            end
        end
        Dividend = a;
        Divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = rnd ? 1'($urandom) : 1'b0;
        Dividend = 8'($urandom);
        Divisor  = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            if (rnd) out_ready = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, ".lat"}, lat, elat);
        check({tag, ".q"}, Quotient, eq);
        check({tag, ".r"}, Remainder, er);
        check({tag, ".dbz"}, Div_By_Zero, ez);
        check({tag, ".ovf"}, Overflow, eo);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, ".hold_q"}, Quotient, eq);
            check({tag, ".hold_r"}, Remainder, er);
            check({tag, ".hold_flags"}, {Div_By_Zero, Overflow}, {ez, eo});
            check({tag, ".hold_hs"}, {in_ready, out_valid}, 2'b01);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".release"}, {in_ready, out_valid}, 2'b10);
    endtask

    initial begin
        logic [7:0] mq;
        logic [3:0] mr;
        logic       mz;
        logic       mo;
        int         mlat;
        bit         seen;

        vecs[0]  = '{8'd100, 4'd7,  8'h0E, 4'h2, 1'b0, 1'b0, 10};
        vecs[1]  = '{8'h9C,  4'd7,  8'hF2, 4'hE, 1'b0, 1'b0, 10};
        vecs[2]  = '{8'd100, 4'h8,  8'hF4, 4'h4, 1'b0, 1'b0, 10};
        vecs[3]  = '{8'h80,  4'hF,  8'h80, 4'h0, 1'b0, 1'b1, 1};
        vecs[4]  = '{8'd5,   4'h0,  8'hFF, 4'h0, 1'b1, 1'b0, 1};
        vecs[5]  = '{8'h80,  4'h1,  8'h80, 4'h0, 1'b0, 1'b0, 10};
        vecs[6]  = '{8'h7F,  4'h8,  8'hF1, 4'h7, 1'b0, 1'b0, 10};
        vecs[7]  = '{8'hF9,  4'h3,  8'hFE, 4'hF, 1'b0, 1'b0, 10};
        vecs[8]  = '{8'h80,  4'h8,  8'h10, 4'h0, 1'b0, 1'b0, 10};
        vecs[9]  = '{8'h00,  4'h5,  8'h00, 4'h0, 1'b0, 1'b0, 10};
        vecs[10] = '{8'h07,  4'h7,  8'h01, 4'h0, 1'b0, 1'b0, 10};
        vecs[11] = '{8'hFF,  4'h7,  8'h00, 4'hF, 1'b0, 1'b0, 10};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        Dividend = 8'h00;
        Divisor = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.hs", {in_ready, out_valid}, 2'b10);
        check("reset.q", Quotient, 8'h00);
        check("reset.r", Remainder, 4'h0);
        check("reset.flags", {Div_By_Zero, Overflow}, 2'b00);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].o,
                   vecs[i].lat, (i == 0 || i == 4) ? 5 : 0, 1'b0, $sformatf("vec%0d", i));
        end

        // Reset during the fourth CALC iteration of 100/7.
        Dividend = 8'd100;
        Divisor = 4'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midcalc_rst.hs", {in_ready, out_valid}, 2'b10);
        check("midcalc_rst.q", Quotient, 8'h00);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("midcalc_rst.ready", in_ready, 1'b1);
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("midcalc_rst.no_result", seen, 1'b0);
        run_op(8'd20, 4'd3, 8'h06, 4'h2, 1'b0, 1'b0, 10, 0, 1'b0, "after_rst");

        // Reset while a result is held in DONE clears it without a clock edge.
        Dividend = 8'h7F;
        Divisor = 4'h8;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("done_rst.pre_q", Quotient, 8'hF1);
        check("done_rst.pre_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("done_rst.q", Quotient, 8'h00);
        check("done_rst.r", Remainder, 4'h0);
        check("done_rst.hs", {in_ready, out_valid}, 2'b10);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                model(8'(a), 4'(b), mq, mr, mz, mo, mlat);
                run_op(8'(a), 4'(b), mq, mr, mz, mo, mlat, 0, 1'b1,
                       $sformatf("sweep_%0d_%0d", a, b));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
